// File: rtl/mem_stage_lsu.sv
// Memory stage load/store unit.
// Holds the EX/MEM stage register, runs the data-memory handshake
// (request/grant, then response for loads), builds byte lanes for stores,
// flags misaligned accesses and feeds the MEM/WB register.
module mem_stage_lsu (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        EX_Mem_read_i,
    input  logic        EX_Mem_write_i,
    input  logic [2:0]  EX_Mem_op_size_i,
    input  logic [31:0] EX_ALU_result_i,
    input  logic [31:0] EX_Store_data_i,
    input  logic [4:0]  EX_Rd_i,
    input  logic        EX_Reg_writeE_i,
    input  logic        EX_Rd_source_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        MEM_stall_o,
    output logic        MEM_misalign_o,
    output logic [4:0]  MEM_Rd_o,
    output logic        MEM_Reg_writeE_o,
    output logic        MEM_Rd_source_o,
    output logic [2:0]  MEM_Mem_op_size_o,
    output logic [31:0] MEM_Load_result_o,
    output logic [31:0] MEM_ALU_result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_e;

    // Access width is selected by funct3[1:0]: 00 byte, 01 half, else word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    state_e      state_q, state_d;

    // EX/MEM stage register
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] sdata_q, sdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        regw_q, regw_d;
    logic        rdsrc_q, rdsrc_d;
    logic        misalign_q, misalign_d;

    // MEM/WB register
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_regw_q, wb_regw_d;
    logic        wb_rdsrc_q, wb_rdsrc_d;
    logic [2:0]  wb_size_q, wb_size_d;
    logic [31:0] wb_load_q, wb_load_d;
    logic [31:0] wb_alu_q, wb_alu_d;

    logic        stall_s;
    logic        req_s;
    logic        ex_is_mem_s;
    logic        ex_go_s;
    logic        st_is_store_s;
    logic        st_bad_s;
    logic [1:0]  off_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

    // Decode of the op currently in EX and of the op held in the stage register.
    always_comb begin
        ex_is_mem_s   = EX_Mem_read_i | EX_Mem_write_i;
        ex_go_s       = ex_is_mem_s & ~is_misaligned(EX_Mem_op_size_i[1:0], EX_ALU_result_i[1:0]);
        st_is_store_s = wr_en_q;
        off_s         = alu_q[1:0];
        st_bad_s      = (rd_en_q | wr_en_q) & is_misaligned(size_q[1:0], off_s);
    end

    // Handshake state machine: next state, request and stall.
    always_comb begin
        state_d = state_q;
        stall_s = 1'b0;
        req_s   = 1'b0;
        case (state_q)
            IDLE: begin
                stall_s = 1'b0;
            end
            REQ: begin
                req_s   = 1'b1;
                stall_s = ~(dmem_gnt_i & st_is_store_s);
                if (dmem_gnt_i) begin
                    state_d = st_is_store_s ? IDLE : RESP;
                end else begin
                    state_d = REQ;
                end
            end
            RESP: begin
                stall_s = ~dmem_rvalid_i;
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Completing (or idle) cycle captures the next op: chain straight into REQ.
        if (!stall_s) begin
            state_d = ex_go_s ? REQ : IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Store byte-lane enables and replicated write data.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
        case (size_q[1:0])
            2'b00: begin
                be_s    = 4'b0001 << off_s;
                wdata_s = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                be_s    = 4'b0011 << off_s;
                wdata_s = {2{sdata_q[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = sdata_q;
            end
        endcase
    end

    // Stage register: capture EX when not stalled, otherwise hold.
    always_comb begin
        if (!stall_s) begin
            rd_en_d    = EX_Mem_read_i & ~EX_Mem_write_i;
            wr_en_d    = EX_Mem_write_i;
            size_d     = EX_Mem_op_size_i;
            alu_d      = EX_ALU_result_i;
            sdata_d    = EX_Store_data_i;
            rd_d       = EX_Rd_i;
            regw_d     = EX_Reg_writeE_i;
            rdsrc_d    = EX_Rd_source_i;
            misalign_d = ex_is_mem_s & ~ex_go_s;
        end else begin
            rd_en_d    = rd_en_q;
            wr_en_d    = wr_en_q;
            size_d     = size_q;
            alu_d      = alu_q;
            sdata_d    = sdata_q;
            rd_d       = rd_q;
            regw_d     = regw_q;
            rdsrc_d    = rdsrc_q;
            misalign_d = 1'b0;
        end
    end

    // MEM/WB register: advance when not stalled, insert a bubble when stalled.
    always_comb begin
        if (!stall_s) begin
            wb_rd_d    = rd_q;
            wb_regw_d  = regw_q & ~st_bad_s;
            wb_rdsrc_d = rdsrc_q;
            wb_size_d  = size_q;
            wb_load_d  = dmem_rdata_i >> {off_s, 3'b000};
            wb_alu_d   = alu_q;
        end else begin
            wb_rd_d    = wb_rd_q;
            wb_regw_d  = 1'b0;
            wb_rdsrc_d = wb_rdsrc_q;
            wb_size_d  = wb_size_q;
            wb_load_d  = wb_load_q;
            wb_alu_d   = wb_alu_q;
        end
    end

    // State, stage and writeback flops with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            size_q     <= 3'b000;
            alu_q      <= 32'h0000_0000;
            sdata_q    <= 32'h0000_0000;
            rd_q       <= 5'd0;
            regw_q     <= 1'b0;
            rdsrc_q    <= 1'b0;
            misalign_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_regw_q  <= 1'b0;
            wb_rdsrc_q <= 1'b0;
            wb_size_q  <= 3'b000;
            wb_load_q  <= 32'h0000_0000;
            wb_alu_q   <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            size_q     <= size_d;
            alu_q      <= alu_d;
            sdata_q    <= sdata_d;
            rd_q       <= rd_d;
            regw_q     <= regw_d;
            rdsrc_q    <= rdsrc_d;
            misalign_q <= misalign_d;
            wb_rd_q    <= wb_rd_d;
            wb_regw_q  <= wb_regw_d;
            wb_rdsrc_q <= wb_rdsrc_d;
            wb_size_q  <= wb_size_d;
            wb_load_q  <= wb_load_d;
            wb_alu_q   <= wb_alu_d;
        end
    end

    // Output drive; memory attributes only while a request is up so they stay stable.
    always_comb begin
        dmem_req_o        = req_s;
        dmem_we_o         = req_s & st_is_store_s;
        dmem_addr_o       = req_s ? {alu_q[31:2], 2'b00} : 32'h0000_0000;
        dmem_be_o         = req_s ? be_s : 4'b0000;
        dmem_wdata_o      = req_s ? wdata_s : 32'h0000_0000;
        MEM_stall_o       = stall_s;
        MEM_misalign_o    = misalign_q;
        MEM_Rd_o          = wb_rd_q;
        MEM_Reg_writeE_o  = wb_regw_q;
        MEM_Rd_source_o   = wb_rdsrc_q;
        MEM_Mem_op_size_o = wb_size_q;
        MEM_Load_result_o = wb_load_q;
        MEM_ALU_result_o  = wb_alu_q;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed ops, random ops and resets,
// checked cycle by cycle against a transaction-level model of the stage.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        EX_Mem_read_i, EX_Mem_write_i;
    logic [2:0]  EX_Mem_op_size_i;
    logic [31:0] EX_ALU_result_i, EX_Store_data_i;
    logic [4:0]  EX_Rd_i;
    logic        EX_Reg_writeE_i, EX_Rd_source_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        MEM_stall_o, MEM_misalign_o;
    logic [4:0]  MEM_Rd_o;
    logic        MEM_Reg_writeE_o, MEM_Rd_source_o;
    logic [2:0]  MEM_Mem_op_size_o;
    logic [31:0] MEM_Load_result_o, MEM_ALU_result_o;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .EX_Mem_read_i(EX_Mem_read_i), .EX_Mem_write_i(EX_Mem_write_i),
        .EX_Mem_op_size_i(EX_Mem_op_size_i), .EX_ALU_result_i(EX_ALU_result_i),
        .EX_Store_data_i(EX_Store_data_i), .EX_Rd_i(EX_Rd_i),
        .EX_Reg_writeE_i(EX_Reg_writeE_i), .EX_Rd_source_i(EX_Rd_source_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .MEM_stall_o(MEM_stall_o), .MEM_misalign_o(MEM_misalign_o),
        .MEM_Rd_o(MEM_Rd_o), .MEM_Reg_writeE_o(MEM_Reg_writeE_o),
        .MEM_Rd_source_o(MEM_Rd_source_o), .MEM_Mem_op_size_o(MEM_Mem_op_size_o),
        .MEM_Load_result_o(MEM_Load_result_o), .MEM_ALU_result_o(MEM_ALU_result_o)
    );

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  sz;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] rdat;
        logic [4:0]  rd;
        logic        rw;
        logic        rs;
        int          gd;    // REQ cycles without grant before grant
        int          rdly;  // RESP cycles without rvalid before rvalid
    } op_t;

    op_t q[$];
    op_t mem_op, ex_op, nop_op;
    int  errors = 0;
    int  checks = 0;
    bit  granted, force_rv;
    int  gcnt, rcnt;

    // expected MEM/WB contents
    logic [4:0]  e_rd;
    logic        e_rw, e_rs;
    logic [2:0]  e_sz;
    logic [31:0] e_lr, e_alu;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input op_t o);
        if (o.sz[1:0] == 2'b00) return 1;
        if (o.sz[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_mem(input op_t o);
        return o.rd_en | o.wr_en;
    endfunction

    function automatic bit aligned(input op_t o);
        return (int'(o.alu[1:0]) % nbytes(o)) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input op_t o);
        int v;
        v = ((1 << nbytes(o)) - 1) << int'(o.alu[1:0]);
        return 4'(v);
    endfunction

    function automatic logic [31:0] exp_wd(input op_t o);
        if (nbytes(o) == 1) return {24'd0, o.sd[7:0]} * 32'h0101_0101;
        if (nbytes(o) == 2) return {16'd0, o.sd[15:0]} * 32'h0001_0001;
        return o.sd;
    endfunction

    function automatic op_t mk(input bit r, input bit w, input logic [2:0] sz, input logic [31:0] alu,
                               input logic [31:0] sd, input logic [4:0] rd, input bit rw,
                               input int gd, input int rdly, input logic [31:0] rdat);
        op_t o;
        o.rd_en = r; o.wr_en = w; o.sz = sz; o.alu = alu; o.sd = sd; o.rdat = rdat;
        o.rd = rd; o.rw = rw; o.rs = r & ~w; o.gd = gd; o.rdly = rdly;
        return o;
    endfunction

    task automatic check_wb();
        check_val("wb_rd", 32'(MEM_Rd_o), 32'(e_rd));
        check_val("wb_regw", 32'(MEM_Reg_writeE_o), 32'(e_rw));
        check_val("wb_rdsrc", 32'(MEM_Rd_source_o), 32'(e_rs));
        check_val("wb_size", 32'(MEM_Mem_op_size_o), 32'(e_sz));
        check_val("wb_alu", MEM_ALU_result_o, e_alu);
        check_val("wb_load", MEM_Load_result_o, e_lr);
    endtask

    // One clock cycle; entered just after a negedge, leaves just after the next one.
    task automatic step();
        bit pend, store, g, rv, comp, stall_e;
        logic [31:0] rdv;
        pend  = is_mem(mem_op) && aligned(mem_op);
        store = mem_op.wr_en;
        if (pend && !granted) g = (gcnt >= mem_op.gd);
        else                  g = 1'($urandom_range(0, 1));
        if (pend && granted)  rv = (rcnt >= mem_op.rdly);
        else                  rv = force_rv | 1'($urandom_range(0, 1));
        force_rv = 1'b0;
        rdv = (pend && !store) ? mem_op.rdat : $urandom;
        EX_Mem_read_i    = ex_op.rd_en;
        EX_Mem_write_i   = ex_op.wr_en;
        EX_Mem_op_size_i = ex_op.sz;
        EX_ALU_result_i  = ex_op.alu;
        EX_Store_data_i  = ex_op.sd;
        EX_Rd_i          = ex_op.rd;
        EX_Reg_writeE_i  = ex_op.rw;
        EX_Rd_source_i   = ex_op.rs;
        dmem_gnt_i       = g;
        dmem_rvalid_i    = rv;
        dmem_rdata_i     = rdv;
        comp    = pend && ((!granted && g && store) || (granted && rv));
        stall_e = pend && !comp;
        #1;
        check_val("req", 32'(dmem_req_o), 32'(pend && !granted));
        check_val("stall", 32'(MEM_stall_o), 32'(stall_e));
        check_val("misalign", 32'(MEM_misalign_o), 32'(is_mem(mem_op) && !aligned(mem_op)));
        if (pend && !granted) begin
            check_val("addr", dmem_addr_o, {mem_op.alu[31:2], 2'b00});
            check_val("be", 32'(dmem_be_o), 32'(exp_be(mem_op)));
            check_val("we", 32'(dmem_we_o), 32'(store));
            if (store) check_val("wdata", dmem_wdata_o, exp_wd(mem_op));
        end
        check_wb();
        @(posedge clk);
        if (!stall_e) begin
            e_rd  = mem_op.rd;
            e_rw  = mem_op.rw && !(is_mem(mem_op) && !aligned(mem_op));
            e_rs  = mem_op.rs;
            e_sz  = mem_op.sz;
            e_alu = mem_op.alu;
            e_lr  = rdv >> (8 * int'(mem_op.alu[1:0]));
            mem_op = ex_op;
            ex_op  = (q.size() > 0) ? q.pop_front() : nop_op;
            granted = 1'b0; gcnt = 0; rcnt = 0;
        end else begin
            e_rw = 1'b0;
            if (!granted) begin
                if (g) granted = 1'b1;
                else   gcnt++;
            end else begin
                rcnt++;
            end
        end
        @(negedge clk);
    endtask

    // Hold reset for n edges, then check that everything reads zero.
    task automatic do_reset(input int n);
        rst_n_i       = 1'b0;
        dmem_gnt_i    = 1'($urandom_range(0, 1));
        dmem_rvalid_i = 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        mem_op = nop_op; granted = 1'b0; gcnt = 0; rcnt = 0;
        e_rd = 5'd0; e_rw = 1'b0; e_rs = 1'b0; e_sz = 3'd0; e_lr = 32'd0; e_alu = 32'd0;
        #1;
        check_val("rst_req", 32'(dmem_req_o), 32'd0);
        check_val("rst_stall", 32'(MEM_stall_o), 32'd0);
        check_val("rst_misalign", 32'(MEM_misalign_o), 32'd0);
        check_val("rst_we", 32'(dmem_we_o), 32'd0);
        check_val("rst_addr", dmem_addr_o, 32'd0);
        check_val("rst_be", 32'(dmem_be_o), 32'd0);
        check_val("rst_wdata", dmem_wdata_o, 32'd0);
        check_wb();
        rst_n_i = 1'b1;
    endtask

    task automatic run_all();
        int n;
        n = 0;
        while ((q.size() > 0 || is_mem(mem_op) || is_mem(ex_op)) && n < 5000) begin
            step();
            n++;
        end
        check_val("drain_budget", 32'(n < 5000), 32'd1);
        step();
        step();
    endtask

    initial begin
        logic [2:0] ld_sz[5];
        logic [2:0] sz;
        int kind, n;
        ld_sz[0] = 3'b000; ld_sz[1] = 3'b001; ld_sz[2] = 3'b010; ld_sz[3] = 3'b100; ld_sz[4] = 3'b101;
        nop_op = mk(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 0, 0, 32'd0);
        mem_op = nop_op; ex_op = nop_op; force_rv = 1'b0;
        EX_Mem_read_i = 1'b0; EX_Mem_write_i = 1'b0; EX_Mem_op_size_i = 3'd0;
        EX_ALU_result_i = 32'd0; EX_Store_data_i = 32'd0; EX_Rd_i = 5'd0;
        EX_Reg_writeE_i = 1'b0; EX_Rd_source_i = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0; rst_n_i = 1'b0;
        @(negedge clk);
        do_reset(3);

        // directed: SB, LW with late grant, LHU, misaligned SW, ADD/SH/LB back-to-back
        q.push_back(mk(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 5'd0, 1'b0, 0, 0, 32'd0));
        q.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'd0, 5'd7, 1'b1, 2, 0, 32'hDEAD_BEEF));
        q.push_back(mk(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 5'd8, 1'b1, 1, 1, 32'h8001_1234));
        q.push_back(mk(1'b0, 1'b1, 3'b010, 32'h0000_3002, 32'h1234_5678, 5'd9, 1'b1, 0, 0, 32'd0));
        q.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 0, 0, 32'd0));
        q.push_back(mk(1'b0, 1'b1, 3'b001, 32'h0000_0042, 32'h0000_BEEF, 5'd0, 1'b0, 0, 0, 32'd0));
        q.push_back(mk(1'b1, 1'b0, 3'b000, 32'h0000_0043, 32'd0, 5'd6, 1'b1, 1, 1, 32'hA5B6_C7D8));
        run_all();

        // random ops, including read+write (treated as store) and misaligned addresses
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 2);
            if (kind == 1) sz = ld_sz[$urandom_range(0, 4)];
            else           sz = 3'($urandom_range(0, 2));
            q.push_back(mk(kind == 1 || (kind == 2 && $urandom_range(0, 7) == 0), kind == 2, sz,
                           $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
                           $urandom_range(0, 3), $urandom_range(0, 3), $urandom));
        end
        run_all();

        // reset while waiting for a load response, then a stray rvalid
        q.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'd0, 5'd3, 1'b1, 0, 40, 32'h1111_2222));
        n = 0;
        while (!(granted && is_mem(mem_op)) && n < 20) begin
            step();
            n++;
        end
        check_val("reached_resp", 32'(granted), 32'd1);
        do_reset(1);
        force_rv = 1'b1;
        step();
        step();
        run_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
